// File: rtl/nco_mix_decim_pkg.sv
// Shared DSP helpers for the NCO mixer/decimator: accumulator sizing,
// output FSM state type and the accumulator-to-output reduction.
package dsp_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mix_state_t;

  function automatic int acc_width(input int in_w, input int lo_w, input int decim);
    return in_w + lo_w + $clog2(decim);
  endfunction

  // Arithmetic right shift by 'shift'; with round_en, adds half an LSB first
  // and clamps to the signed out_w range so the caller can take the low bits.
  function automatic logic signed [63:0] reduce_acc(input logic signed [63:0] v,
                                                    input int shift,
                                                    input int out_w,
                                                    input bit round_en);
    logic signed [63:0] t;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    t = v;
    if (round_en && shift > 0) t = t + (64'sd1 <<< (shift - 1));
    t  = t >>> shift;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (round_en) begin
      if (t > hi) t = hi;
      else if (t < lo) t = lo;
    end
    return t;
  endfunction

endpackage

// File: rtl/nco_mix_decim_if.sv
// Sample/LO input and decimated I/Q output bundle of nco_mix_decim.
// Output handshake: a result transfers on any rising edge where out_valid && out_ready;
// the input side has no ready and is never back-pressured.
interface nco_mix_decim_if #(
  parameter int IN_W  = 8,
  parameter int LO_W  = 8,
  parameter int OUT_W = 16
);
  logic signed [IN_W-1:0]  in_sample;
  logic                    in_valid;
  logic signed [LO_W-1:0]  lo_sin;
  logic signed [LO_W-1:0]  lo_cos;
  logic signed [OUT_W-1:0] out_i;
  logic signed [OUT_W-1:0] out_q;
  logic                    out_valid;
  logic                    out_ready;

  modport slave (
    input  in_sample, in_valid, lo_sin, lo_cos, out_ready,
    output out_i, out_q, out_valid
  );

  modport master (
    output in_sample, in_valid, lo_sin, lo_cos, out_ready,
    input  out_i, out_q, out_valid
  );
endinterface

// File: rtl/nco_mix_decim_acc.sv
// One mixer channel: registered full-precision product, then accumulate
// and dump on the shared window counter's last step.
module mix_acc #(
  parameter int IN_W  = 8,
  parameter int LO_W  = 8,
  parameter int ACC_W = 18
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic                    step,
  input  logic                    last,
  input  logic signed [IN_W-1:0]  sample,
  input  logic signed [LO_W-1:0]  lo,
  output logic signed [ACC_W-1:0] dump
);
  localparam int P_W = IN_W + LO_W;

  logic signed [P_W-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;

  assign sum = acc + {{(ACC_W - P_W){prod[P_W-1]}}, prod};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod <= '0;
      acc  <= '0;
      dump <= '0;
    end else if (en) begin
      if (load) prod <= P_W'(sample) * P_W'(lo);
      if (step) begin
        // Last product of the window goes straight into the dump; the next
        // window starts from zero with no idle cycle.
        if (last) begin
          dump <= sum;
          acc  <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end
endmodule

// File: rtl/nco_mix_decim.sv
// Real-input I/Q mixer with integrate-and-dump decimation and a one-deep
// valid/ready output slot. Build option: MIX_DECIM_ROUND_EN (round + saturate).
module nco_mix_decim
  import dsp_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int LO_W  = 8,
  parameter int DECIM = 4,
  parameter int OUT_W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr_overrun,
  nco_mix_decim_if.slave bus,
  output logic         overrun,
  output mix_state_t   state
);
  localparam int ACC_W = acc_width(IN_W, LO_W, DECIM);
  localparam int CNT_W = $clog2(DECIM);
  localparam int SHIFT = ACC_W - OUT_W;
`ifdef MIX_DECIM_ROUND_EN
  localparam bit ROUND = (SHIFT > 0);
`else
  localparam bit ROUND = 1'b0;
`endif

  logic                    accept;
  logic                    p_valid;
  logic [CNT_W-1:0]        cnt;
  logic                    last;
  logic                    dump_valid;
  logic                    dump_fire;
  logic                    handshake;
  logic                    load_out;
  logic                    set_ovr;
  logic signed [ACC_W-1:0] dump_i;
  logic signed [ACC_W-1:0] dump_q;
  logic signed [OUT_W-1:0] red_i;
  logic signed [OUT_W-1:0] red_q;
  mix_state_t              state_next;

  assign accept = en && bus.in_valid;
  assign last   = (cnt == CNT_W'(DECIM - 1));

  mix_acc #(.IN_W(IN_W), .LO_W(LO_W), .ACC_W(ACC_W)) u_acc_i (
    .clk(clk), .rst(rst), .en(en), .load(accept), .step(p_valid), .last(last),
    .sample(bus.in_sample), .lo(bus.lo_cos), .dump(dump_i)
  );

  mix_acc #(.IN_W(IN_W), .LO_W(LO_W), .ACC_W(ACC_W)) u_acc_q (
    .clk(clk), .rst(rst), .en(en), .load(accept), .step(p_valid), .last(last),
    .sample(bus.in_sample), .lo(bus.lo_sin), .dump(dump_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      p_valid    <= 1'b0;
      cnt        <= '0;
      dump_valid <= 1'b0;
    end else if (en) begin
      p_valid    <= bus.in_valid;
      dump_valid <= p_valid && last;
      if (p_valid) cnt <= last ? '0 : cnt + 1'b1;
    end
  end

  // A pending dump is held while disabled and only lands once en returns.
  assign dump_fire = en && dump_valid;
  assign handshake = bus.out_valid && bus.out_ready;

  assign red_i = OUT_W'(reduce_acc(64'(dump_i), SHIFT, OUT_W, ROUND));
  assign red_q = OUT_W'(reduce_acc(64'(dump_q), SHIFT, OUT_W, ROUND));

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ACCUM:   if (dump_fire) state_next = HOLD;
      HOLD:    if (handshake && !dump_fire) state_next = ACCUM;
      default: state_next = ACCUM;
    endcase
  end

  always_comb begin
    bus.out_valid = (state == HOLD);
    load_out      = dump_fire && ((state == ACCUM) || handshake);
    set_ovr       = dump_fire && (state == HOLD) && !handshake;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_i <= '0;
      bus.out_q <= '0;
      overrun   <= 1'b0;
    end else begin
      if (load_out) begin
        bus.out_i <= red_i;
        bus.out_q <= red_q;
      end
      if (set_ovr)          overrun <= 1'b1;
      else if (clr_overrun) overrun <= 1'b0;
    end
  end
endmodule

// File: tb/tb_nco_mix_decim.sv
// Bench for nco_mix_decim: directed corner cases plus random streams checked
// against a window-sum reference model and an expected-result queue.
module tb_nco_mix_decim;
  import dsp_pkg::*;

  localparam int IN_W  = 8;
  localparam int LO_W  = 8;
  localparam int DECIM = 4;
  localparam int OUT_W = 16;
  localparam int ACC_W = IN_W + LO_W + $clog2(DECIM);
  localparam int SHIFT = ACC_W - OUT_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       clr_overrun;
  logic       overrun;
  mix_state_t state;

  nco_mix_decim_if #(.IN_W(IN_W), .LO_W(LO_W), .OUT_W(OUT_W)) bus ();

  nco_mix_decim #(.IN_W(IN_W), .LO_W(LO_W), .DECIM(DECIM), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr_overrun(clr_overrun),
    .bus(bus), .overrun(overrun), .state(state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint win_i[$];
  longint win_q[$];
  logic [2*OUT_W-1:0] exp_q[$];

  function automatic longint reduce(input longint s);
    real    scaled;
    longint r;
    longint hi;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    scaled = real'(s) / real'(longint'(1) << SHIFT);
`ifdef MIX_DECIM_ROUND_EN
    r = longint'($floor(scaled + 0.5));
    if (r > hi) r = hi;
    if (r < -hi - 1) r = -hi - 1;
`else
    r = longint'($floor(scaled));
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      win_i.delete();
      win_q.delete();
      exp_q.delete();
    end else if (en && bus.in_valid) begin
      longint si, sq;
      logic [OUT_W-1:0] ri, rq;
      win_i.push_back(longint'(bus.in_sample) * longint'(bus.lo_cos));
      win_q.push_back(longint'(bus.in_sample) * longint'(bus.lo_sin));
      if (win_i.size() == DECIM) begin
        si = 0;
        sq = 0;
        foreach (win_i[k]) begin
          si += win_i[k];
          sq += win_q[k];
        end
        ri = OUT_W'(reduce(si));
        rq = OUT_W'(reduce(sq));
        exp_q.push_back({ri, rq});
        win_i.delete();
        win_q.delete();
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [OUT_W-1:0] prev_i, prev_q;
  logic             prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_i", longint'(bus.out_i), longint'($signed(prev_i)));
        check("hold_q", longint'(bus.out_q), longint'($signed(prev_q)));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          logic [2*OUT_W-1:0] e;
          logic [OUT_W-1:0]   ei, eq;
          e  = exp_q.pop_front();
          ei = e[2*OUT_W-1:OUT_W];
          eq = e[OUT_W-1:0];
          check("out_i", longint'(bus.out_i), longint'($signed(ei)));
          check("out_q", longint'(bus.out_q), longint'($signed(eq)));
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_i     = bus.out_i;
      prev_q     = bus.out_q;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic signed [IN_W-1:0] s,
                       input logic signed [LO_W-1:0] si, input logic signed [LO_W-1:0] co);
    bus.in_valid  = v;
    bus.in_sample = s;
    bus.lo_sin    = si;
    bus.lo_cos    = co;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drive_rand(input int n);
    repeat (n) drive(1'b1, IN_W'($urandom), LO_W'($urandom), LO_W'($urandom));
  endtask

  // Wait for the latency point of the window just completed: out_valid must
  // be low after the accept edge and the next one, high after the third.
  task automatic check_latency(input string tag);
    @(negedge clk);
    check({tag, "_lat1"}, longint'(bus.out_valid), 0);
    @(negedge clk);
    check({tag, "_lat2"}, longint'(bus.out_valid), 0);
    @(negedge clk);
    check({tag, "_lat3"}, longint'(bus.out_valid), 1);
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 60;
    while (exp_q.size() != 0 && budget > 0) begin
      idle(1);
      budget--;
    end
    check({tag, "_drain"}, longint'(exp_q.size()), 0);
  endtask

  logic signed [IN_W-1:0] stream_s  [12];
  logic signed [LO_W-1:0] stream_si [12];
  logic signed [LO_W-1:0] stream_co [12];

  // ---------------- test sequence ----------------
  initial begin
    int n0;
    longint held_i, held_q;
    longint exp3;

    rst = 1'b1;
    en = 1'b1;
    clr_overrun = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sample = '0;
    bus.lo_sin = '0;
    bus.lo_cos = '0;
    bus.out_ready = 1'b1;
    idle(2);
    @(negedge clk);
    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_i", longint'(bus.out_i), 0);
    check("rst_q", longint'(bus.out_q), 0);
    check("rst_ovr", longint'(overrun), 0);
    check("rst_state", longint'(state), longint'(ACCUM));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Pure sine LO: only Q accumulates.
    n0 = n_out;
    repeat (3) drive(1'b1, 8'sd100, 8'sd127, 8'sd0);
    drive(1'b1, 8'sd100, 8'sd127, 8'sd0);
    check_latency("t1");
    check("t1_q", longint'(bus.out_q), 12700);
    check("t1_i", longint'(bus.out_i), 0);
    idle(4);
    check("t1_count", longint'(n_out - n0), 1);

    // Most negative operands: sign extension and headroom.
    repeat (4) drive(1'b1, -8'sd128, -8'sd128, -8'sd128);
    check_latency("t2");
    check("t2_i", longint'(bus.out_i), 16384);
    check("t2_q", longint'(bus.out_q), 16384);
    idle(3);

    // Sum of 6 exercises the fractional part of the reduction.
    drive(1'b1, 8'sd1, 8'sd1, 8'sd0);
    drive(1'b1, 8'sd1, 8'sd1, 8'sd0);
    drive(1'b1, 8'sd1, 8'sd2, 8'sd0);
    drive(1'b1, 8'sd1, 8'sd2, 8'sd0);
    check_latency("t3");
`ifdef MIX_DECIM_ROUND_EN
    exp3 = 2;
`else
    exp3 = 1;
`endif
    check("t3_q", longint'(bus.out_q), exp3);
    idle(3);

    // Output stalled across two windows: second dump dropped, overrun set.
    bus.out_ready = 1'b0;
    drive_rand(4);
    idle(3);
    @(negedge clk);
    check("t4_valid", longint'(bus.out_valid), 1);
    held_i = longint'(bus.out_i);
    held_q = longint'(bus.out_q);
    @(posedge clk);
    #1;
    drive_rand(4);
    idle(3);
    @(negedge clk);
    check("t4_ovr", longint'(overrun), 1);
    check("t4_state", longint'(state), longint'(HOLD));
    check("t4_held_i", longint'(bus.out_i), held_i);
    check("t4_held_q", longint'(bus.out_q), held_q);
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());

    // Clear while quiet, then clear coinciding with a new drop: set wins.
    drive_rand(3);
    clr_overrun = 1'b1;
    drive_rand(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    check("t4_clr", longint'(overrun), 0);
    @(posedge clk);
    #1;
    clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    @(negedge clk);
    check("t4_set_wins", longint'(overrun), 1);
    check("t4_held2_i", longint'(bus.out_i), held_i);
    @(posedge clk);
    #1;
    void'(exp_q.pop_back());
    bus.out_ready = 1'b1;
    drain("t4");
    clr_overrun = 1'b1;
    idle(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    check("t4_clr2", longint'(overrun), 0);
    @(posedge clk);
    #1;

    // Continuous stream, then the same stream with a 5-cycle enable gap.
    foreach (stream_s[k]) begin
      stream_s[k]  = IN_W'($urandom);
      stream_si[k] = LO_W'($urandom);
      stream_co[k] = LO_W'($urandom);
    end
    n0 = n_out;
    for (int k = 0; k < 12; k++) drive(1'b1, stream_s[k], stream_si[k], stream_co[k]);
    idle(6);
    check("t5_count", longint'(n_out - n0), 3);
    check("t5_ovr", longint'(overrun), 0);
    n0 = n_out;
    for (int k = 0; k < 6; k++) drive(1'b1, stream_s[k], stream_si[k], stream_co[k]);
    en = 1'b0;
    drive_rand(5);
    en = 1'b1;
    for (int k = 6; k < 12; k++) drive(1'b1, stream_s[k], stream_si[k], stream_co[k]);
    idle(6);
    check("t5_en_count", longint'(n_out - n0), 3);
    check("t5_en_ovr", longint'(overrun), 0);

    // Reset in the middle of a window discards the partial sum.
    drive_rand(2);
    pulse_reset();
    repeat (4) drive(1'b1, 8'sd10, 8'sd0, 8'sd10);
    check_latency("t6");
    check("t6_i", longint'(bus.out_i), 100);
    check("t6_q", longint'(bus.out_q), 0);
    idle(3);

    // Random stream with random enable and sparse input.
    n0 = n_out;
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 9) < 8);
      drive(($urandom_range(0, 9) < 6), IN_W'($urandom), LO_W'($urandom), LO_W'($urandom));
    end
    en = 1'b1;
    drain("t7");
    check("t7_ovr", longint'(overrun), 0);
    check("t7_some_out", longint'(n_out - n0 > 20), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
